// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic-tutorial package: serial subtractor FSM states and defaults.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result ready-valid bundle for the serial subtractor.
interface serial_subtractor_if
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             b_out;

    // Producer/consumer side
    modport master (
        output in_valid, x, y, b_in, out_ready,
        input  in_ready, out_valid, d, b_out
    );

    // Subtractor side
    modport slave (
        input  in_valid, x, y, b_in, out_ready,
        output in_ready, out_valid, d, b_out
    );
endinterface

// File: rtl/serial_subtractor_full_sub.sv
// Single-bit subtractor cells: half subtractor and a full subtractor built
// from two half stages plus an OR, the borrow-chain twin of the full adder.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic b
);
    assign d = x ^ y;
    assign b = ~x & y;
endmodule

module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic b_in,
    output logic d,
    output logic b_out
);
    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (.x(x),  .y(y),    .d(d1), .b(b1));
    half_subtractor u_hs1 (.x(d1), .y(b_in), .d(d),  .b(b2));

    // A borrow arises from either stage; they never both fire.
    assign b_out = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: d = x - y - b_in over WIDTH RUN cycles,
// with ready/valid handshakes on the operand and result sides.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_subtractor_if.slave bus
);
    // Bit counter needs at least one bit even for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sub_state_t       state_q,     state_d;
    logic [WIDTH-1:0] x_sh_q,      x_sh_d;
    logic [WIDTH-1:0] y_sh_q,      y_sh_d;
    logic [WIDTH-1:0] d_sh_q,      d_sh_d;
    logic [WIDTH-1:0] d_res_q,     d_res_d;
    logic             borrow_q,    borrow_d;
    logic             b_res_q,     b_res_d;
    logic [CW-1:0]    count_q,     count_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             bit_diff;
    logic             bit_borrow;
    logic [WIDTH-1:0] d_sh_shift;

    full_subtractor u_fs (
        .x     (x_sh_q[0]),
        .y     (y_sh_q[0]),
        .b_in  (borrow_q),
        .d     (bit_diff),
        .b_out (bit_borrow)
    );

    // New difference bit enters at the MSB so the LSB lands in bit 0 last.
    if (WIDTH == 1) begin : g_sh1
        assign d_sh_shift = bit_diff;
    end else begin : g_shn
        assign d_sh_shift = {bit_diff, d_sh_q[WIDTH-1:1]};
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        x_sh_d      = x_sh_q;
        y_sh_d      = y_sh_q;
        d_sh_d      = d_sh_q;
        d_res_d     = d_res_q;
        borrow_d    = borrow_q;
        b_res_d     = b_res_q;
        count_d     = count_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_sh_d     = bus.x;
                    y_sh_d     = bus.y;
                    borrow_d   = bus.b_in;
                    d_sh_d     = '0;
                    count_d    = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                x_sh_d   = x_sh_q >> 1;
                y_sh_d   = y_sh_q >> 1;
                d_sh_d   = d_sh_shift;
                borrow_d = bit_borrow;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    d_res_d     = d_sh_shift;
                    b_res_d     = bit_borrow;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs; async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_sh_q      <= '0;
            y_sh_q      <= '0;
            d_sh_q      <= '0;
            d_res_q     <= '0;
            borrow_q    <= 1'b0;
            b_res_q     <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_sh_q      <= x_sh_d;
            y_sh_q      <= y_sh_d;
            d_sh_q      <= d_sh_d;
            d_res_q     <= d_res_d;
            borrow_q    <= borrow_d;
            b_res_q     <= b_res_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_res_q;
    assign bus.b_out     = b_res_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4 and WIDTH=1 instances).
module tb_serial_subtractor;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_subtractor_if #(.WIDTH(4)) bus4 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       bi;
        int         stall;
        logic [3:0] ed;
        logic       eb;
    } vec_t;

    vec_t vecs[6];

    // Reference: plain integer subtraction, truncated to w bits; borrow = negative.
    function automatic logic [32:0] ref_sub(int w, logic [31:0] a, logic [31:0] b, logic bi);
        longint      diff;
        logic [31:0] mask;
        diff = longint'(a) - longint'(b) - longint'(bi);
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return {diff < 0, diff[31:0] & mask};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=4 transaction: accept, measure latency, hold the result for
    // `stall` cycles while poking in_valid, then release it.
    task automatic op4(string nm, logic [3:0] xa, logic [3:0] ya, logic bi,
                       int stall, logic [3:0] ed, logic eb);
        int n;
        n = 0;
        while (!bus4.in_ready && n < 50) begin tick(); n++; end
        chk({nm, "_in_ready_pre"}, bus4.in_ready, 1);
        bus4.x = xa; bus4.y = ya; bus4.b_in = bi; bus4.in_valid = 1'b1;
        bus4.out_ready = (stall == 0);
        tick();
        bus4.in_valid = 1'b0;
        bus4.x = 4'($urandom); bus4.y = 4'($urandom); bus4.b_in = 1'($urandom);
        n = 1; // the accepting edge counts as the first
        while (!bus4.out_valid && n < 100) begin tick(); n++; end
        chk({nm, "_latency"}, n, 5);
        chk({nm, "_d"}, bus4.d, ed);
        chk({nm, "_b_out"}, bus4.b_out, eb);
        for (int i = 0; i < stall; i++) begin
            bus4.in_valid = i[0];
            bus4.x = 4'd1;
            tick();
            chk({nm, "_hold_valid"}, bus4.out_valid, 1);
            chk({nm, "_hold_in_ready"}, bus4.in_ready, 0);
            chk({nm, "_hold_d"}, bus4.d, ed);
            chk({nm, "_hold_b"}, bus4.b_out, eb);
        end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
        chk({nm, "_valid_drop"}, bus4.out_valid, 0);
        chk({nm, "_in_ready_post"}, bus4.in_ready, 1);
        chk({nm, "_d_retained"}, bus4.d, ed);
        $display("op4 %s x=%0d y=%0d b_in=%0d -> d=%0d b_out=%0d", nm, xa, ya, bi, bus4.d, bus4.b_out);
    endtask

    // One WIDTH=1 transaction with the consumer always ready.
    task automatic op1(string nm, logic xa, logic ya, logic bi, logic ed, logic eb);
        int n;
        n = 0;
        while (!bus1.in_ready && n < 50) begin tick(); n++; end
        bus1.x = xa; bus1.y = ya; bus1.b_in = bi; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        n = 1;
        while (!bus1.out_valid && n < 100) begin tick(); n++; end
        chk({nm, "_latency"}, n, 2);
        chk({nm, "_d"}, bus1.d, ed);
        chk({nm, "_b_out"}, bus1.b_out, eb);
        tick();
        chk({nm, "_valid_drop"}, bus1.out_valid, 0);
        $display("op1 %s x=%0d y=%0d b_in=%0d -> d=%0d b_out=%0d", nm, xa, ya, bi, bus1.d, bus1.b_out);
    endtask

    initial begin
        logic [32:0] r;
        logic [3:0]  bx [3];
        logic [3:0]  by [3];
        int          idx;
        int          results;
        int          cyc;
        int          last_cyc;
        logic        accepting;

        checks = 0;
        failures = 0;
        vecs[0] = '{x: 4'd9,  y: 4'd3,  bi: 1'b0, stall: 0, ed: 4'd6,  eb: 1'b0};
        vecs[1] = '{x: 4'd3,  y: 4'd9,  bi: 1'b0, stall: 0, ed: 4'd10, eb: 1'b1};
        vecs[2] = '{x: 4'd0,  y: 4'd0,  bi: 1'b1, stall: 1, ed: 4'd15, eb: 1'b1};
        vecs[3] = '{x: 4'd15, y: 4'd15, bi: 1'b0, stall: 0, ed: 4'd0,  eb: 1'b0};
        vecs[4] = '{x: 4'd12, y: 4'd5,  bi: 1'b0, stall: 6, ed: 4'd7,  eb: 1'b0};
        vecs[5] = '{x: 4'd5,  y: 4'd2,  bi: 1'b1, stall: 2, ed: 4'd2,  eb: 1'b0};

        bus4.in_valid = 0; bus4.x = 0; bus4.y = 0; bus4.b_in = 0; bus4.out_ready = 0;
        bus1.in_valid = 0; bus1.x = 0; bus1.y = 0; bus1.b_in = 0; bus1.out_ready = 0;
        rst_n = 1'b0;
        #12;
        chk("rst_in_ready", bus4.in_ready, 1);
        chk("rst_out_valid", bus4.out_valid, 0);
        chk("rst_d", bus4.d, 0);
        chk("rst_b_out", bus4.b_out, 0);
        chk("rst1_in_ready", bus1.in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 6; i++)
            op4($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].bi,
                vecs[i].stall, vecs[i].ed, vecs[i].eb);

        // Backpressure sequence: d=7 held through 6 stalled cycles
        op4("bp", 4'd12, 4'd5, 1'b0, 6, 4'd7, 1'b0);

        // Reset mid-RUN: outputs clear without a clock edge
        bus4.x = 4'd8; bus4.y = 4'd1; bus4.b_in = 0; bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus4.out_valid, 0);
        chk("arst_d", bus4.d, 0);
        chk("arst_b_out", bus4.b_out, 0);
        chk("arst_in_ready", bus4.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("arst_no_partial", bus4.out_valid, 0);
        end
        $display("reset mid-RUN: outputs cleared, no partial result");
        op4("post_rst", 4'd5, 4'd2, 1'b0, 0, 4'd3, 1'b0);

        // Back-to-back with in_valid and out_ready held high
        bx[0] = 4'd1; by[0] = 4'd1;
        bx[1] = 4'd2; by[1] = 4'd1;
        bx[2] = 4'd0; by[2] = 4'd1;
        idx = 0; results = 0; cyc = 0; last_cyc = 0;
        bus4.x = bx[0]; bus4.y = by[0]; bus4.b_in = 0;
        bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
        while (results < 3 && cyc < 100) begin
            accepting = bus4.in_ready && bus4.in_valid;
            if (bus4.out_valid) begin
                r = ref_sub(4, 32'(bx[results]), 32'(by[results]), 1'b0);
                chk("b2b_d", bus4.d, r[3:0]);
                chk("b2b_b_out", bus4.b_out, r[32]);
                if (results > 0) chk("b2b_period", cyc - last_cyc, 6);
                $display("b2b result %0d: d=%0d b_out=%0d at cycle %0d", results, bus4.d, bus4.b_out, cyc);
                last_cyc = cyc;
                results++;
            end
            tick();
            cyc++;
            if (accepting) begin
                idx++;
                if (idx < 3) begin
                    bus4.x = bx[idx]; bus4.y = by[idx];
                end else begin
                    bus4.in_valid = 1'b0;
                end
            end
        end
        chk("b2b_count", results, 3);
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b0;
        tick();
        tick();

        // Randomized against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [3:0] rx;
            logic [3:0] ry;
            logic       rb;
            rx = 4'($urandom);
            ry = 4'($urandom);
            rb = 1'($urandom);
            r = ref_sub(4, 32'(rx), 32'(ry), rb);
            op4($sformatf("rnd%0d", i), rx, ry, rb, int'($urandom_range(0, 3)), r[3:0], r[32]);
        end

        // WIDTH=1 instance: table plus all input combinations
        op1("w1_a", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        op1("w1_b", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] c;
            c = 3'(i);
            r = ref_sub(1, 32'(c[2]), 32'(c[1]), c[0]);
            op1($sformatf("w1_all%0d", i), c[2], c[1], c[0], r[0], r[32]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
